// File: rtl/sq_wave_div.sv
// Programmable square-wave divider: half-period updates via valid/ready, applied only at period edges.
// Optional completed-rise counter (cyc_cnt) is built when SQW_CYC_CNT_EN is defined.
module sq_wave_div #(
  parameter int CNT_W    = 16,
  parameter int DEF_HALF = 2
`ifdef SQW_CYC_CNT_EN
  ,
  parameter int CYC_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy
`ifdef SQW_CYC_CNT_EN
  ,
  output logic [CYC_W-1:0] cyc_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN_HI, RUN_LO} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active_half;
  logic [CNT_W-1:0] r_pending_half;
  logic             r_pending;
  logic             r_cfg_ready;
  logic             r_clk_out;
  logic             r_rise;
  logic             r_fall;

  logic             w_accept;
  logic [CNT_W-1:0] w_half_in;
  logic             w_last;
  logic             w_rise_next;

  assign w_accept    = cfg_valid && r_cfg_ready;
  assign w_half_in   = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign w_last      = (r_cnt == r_active_half - CNT_W'(1));
  assign w_rise_next = en && ((r_state == IDLE) || (r_state == RUN_LO && w_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_active_half  <= CNT_W'(DEF_HALF);
      r_pending_half <= '0;
      r_pending      <= 1'b0;
      r_cfg_ready    <= 1'b1;
      r_clk_out      <= 1'b0;
      r_rise         <= 1'b0;
      r_fall         <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) r_active_half <= w_half_in;
          if (en) begin
            r_state   <= RUN_HI;
            r_clk_out <= 1'b1;
            r_rise    <= 1'b1;
            r_cnt     <= '0;
          end
        end
        RUN_HI: begin
          if (w_last) begin
            r_state   <= RUN_LO;
            r_clk_out <= 1'b0;
            r_fall    <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN_LO: begin
          if (w_last) begin
            r_cnt <= '0;
            // Pending value lands at the period boundary, whether we rise again or stop.
            if (r_pending) begin
              r_active_half <= r_pending_half;
              r_pending     <= 1'b0;
              r_cfg_ready   <= 1'b1;
            end
            if (en) begin
              r_state   <= RUN_HI;
              r_clk_out <= 1'b1;
              r_rise    <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_out <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
      // Acceptance implies no pending value, so this never collides with the apply above.
      if (w_accept && r_state != IDLE) begin
        r_pending      <= 1'b1;
        r_pending_half <= w_half_in;
        r_cfg_ready    <= 1'b0;
      end
    end
  end

`ifdef SQW_CYC_CNT_EN
  logic [CYC_W-1:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= '0;
    end else if (w_rise_next) begin
      r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`else
  logic w_unused;
  assign w_unused = w_rise_next;
`endif

  assign cfg_ready = r_cfg_ready;
  assign clk_out   = r_clk_out;
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sq_wave_div.sv
// Directed bench for sq_wave_div: expected per-cycle outputs are queued as each step is driven
// and popped/compared one per clock, sampled 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_sq_wave_div;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic             busy;
`ifdef SQW_CYC_CNT_EN
  logic [31:0]      cyc_cnt;
`endif

  sq_wave_div #(.CNT_W(CNT_W), .DEF_HALF(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .busy      (busy)
`ifdef SQW_CYC_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt)
`endif
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic co;
    logic rt;
    logic ft;
    logic bsy;
    logic rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic co, input logic rt, input logic ft, input logic bsy, input logic rdy);
    exp_t e;
    e.co = co; e.rt = rt; e.ft = ft; e.bsy = bsy; e.rdy = rdy;
    q.push_back(e);
  endtask

  // One phase of n cycles at the given level; the first cycle carries the matching tick.
  task automatic push_phase(input logic lvl, input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      push1(lvl, (i == 0) && lvl, (i == 0) && !lvl, 1'b1, rdy);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() == 0) begin
        chk($sformatf("queue_underflow@%0d", cyc), 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("clk_out@%0d", cyc),   32'(clk_out),   32'(e.co));
        chk($sformatf("rise_tick@%0d", cyc), 32'(rise_tick), 32'(e.rt));
        chk($sformatf("fall_tick@%0d", cyc), 32'(fall_tick), 32'(e.ft));
        chk($sformatf("busy@%0d", cyc),      32'(busy),      32'(e.bsy));
        chk($sformatf("cfg_ready@%0d", cyc), 32'(cfg_ready), 32'(e.rdy));
      end
    end
  endtask

  // Offer one half-period while idle; accepted at the next edge.
  task automatic idle_cfg(input logic [CNT_W-1:0] h);
    cfg_valid = 1'b1;
    cfg_half  = h;
    push_idle(1);
    run(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_rise", 32'(rise_tick), 32'd0);
    chk("rst_fall", 32'(fall_tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
`ifdef SQW_CYC_CNT_EN
    chk("rst_cyc_cnt", cyc_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    push_idle(2);
    run(2);

    // Default half-period 2, then stop at the second boundary.
    en = 1'b1;
    push_phase(1, 2, 1); push_phase(0, 2, 1); push_phase(1, 2, 1); push_phase(0, 2, 1); push_idle(2);
    run(6); en = 1'b0; run(4);

    // Idle configuration to 5.
    idle_cfg(16'd5);
    en = 1'b1;
    push_phase(1, 5, 1); push_phase(0, 5, 1); push_phase(1, 5, 1); push_phase(0, 5, 1); push_idle(1);
    run(11); en = 1'b0; run(10);

    // Running at 2, change to 3 mid-high: takes effect at the next rise.
    idle_cfg(16'd2);
    en = 1'b1;
    cfg_half = 16'd3;
    push1(1, 1, 0, 1, 1); push1(1, 0, 0, 1, 0); push1(0, 0, 1, 1, 0); push1(0, 0, 0, 1, 0);
    push_phase(1, 3, 1); push_phase(0, 3, 1); push_phase(1, 3, 1); push_phase(0, 3, 1); push_idle(1);
    run(1); cfg_valid = 1'b1; run(1); cfg_valid = 1'b0;
    run(9); en = 1'b0; run(6);

    // Drop en during the high phase: the period still completes.
    idle_cfg(16'd4);
    en = 1'b1;
    push_phase(1, 4, 1); push_phase(0, 4, 1); push_idle(3);
    run(2); en = 1'b0; run(9);

    // Zero clamps to one: clk/2.
    idle_cfg(16'd0);
    en = 1'b1;
    push_phase(1, 1, 1); push_phase(0, 1, 1); push_phase(1, 1, 1); push_phase(0, 1, 1); push_idle(2);
    run(4); en = 1'b0; run(2);

    // Async reset mid-high with a pending value of 7 queued.
    idle_cfg(16'd2);
    en = 1'b1;
    push1(1, 1, 0, 1, 1); push1(1, 0, 0, 1, 0);
    run(1); cfg_valid = 1'b1; cfg_half = 16'd7; run(1); cfg_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_clk_out", 32'(clk_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(cfg_ready), 32'd1);
    #2;
    rst_n = 1'b1;
`ifdef SQW_CYC_CNT_EN
    chk("post_rst_cyc_cnt", cyc_cnt, 32'd0);
`endif
    push_phase(1, 2, 1); push_phase(0, 2, 1); push_phase(1, 2, 1); push_phase(0, 2, 1);
    push_phase(1, 2, 1); push_phase(0, 2, 1); push_idle(1);
    run(9); en = 1'b0; run(4);
`ifdef SQW_CYC_CNT_EN
    chk("cyc_cnt_3", cyc_cnt, 32'd3);
`endif

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
